// File: rtl/riscv_alu_exec_pkg.sv
// Shared constants and helpers for the RV32I/RV64I ALU execute stage.
package riscv_alu_exec_pkg;

    localparam int unsigned ALUOP_W = 4;
    typedef logic [ALUOP_W-1:0] aluop_t;

    // Decoded ALU operations
    localparam aluop_t aluop_nop   = 4'd0;
    localparam aluop_t aluop_add   = 4'd1;
    localparam aluop_t aluop_sub   = 4'd2;
    localparam aluop_t aluop_sll   = 4'd3;
    localparam aluop_t aluop_slt   = 4'd4;
    localparam aluop_t aluop_sltu  = 4'd5;
    localparam aluop_t aluop_xor   = 4'd6;
    localparam aluop_t aluop_srl   = 4'd7;
    localparam aluop_t aluop_sra   = 4'd8;
    localparam aluop_t aluop_or    = 4'd9;
    localparam aluop_t aluop_and   = 4'd10;
    localparam aluop_t aluop_passb = 4'd11;

    // Major opcodes
    localparam logic [6:0] op_rtype  = 7'b0110011;
    localparam logic [6:0] op_itype  = 7'b0010011;
    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;
    localparam logic [6:0] op_lui    = 7'b0110111;
    localparam logic [6:0] op_auipc  = 7'b0010111;
    localparam logic [6:0] op_branch = 7'b1100011;

    localparam logic [6:0] f7_base = 7'b0000000;
    localparam logic [6:0] f7_alt  = 7'b0100000;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_shift = 2'd1,
        st_done  = 2'd2
    } state_e;

    // funct3 to base (non-alternate) operation for R/I arithmetic
    function automatic aluop_t base_aluop(input logic [2:0] f3);
        case (f3)
            3'b000:  return aluop_add;
            3'b001:  return aluop_sll;
            3'b010:  return aluop_slt;
            3'b011:  return aluop_sltu;
            3'b100:  return aluop_xor;
            3'b101:  return aluop_srl;
            3'b110:  return aluop_or;
            default: return aluop_and;
        endcase
    endfunction

    function automatic logic is_shift_op(input aluop_t op);
        return (op == aluop_sll) || (op == aluop_srl) || (op == aluop_sra);
    endfunction

endpackage

// File: rtl/riscv_alu_exec_decode.sv
// Combinational opcode/funct3/funct7 decode into ALU op, illegal flag and shift flag.
module riscv_alu_decode
    import riscv_alu_exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output aluop_t     aluop_c_o,
    output logic       illegal_c_o,
    output logic       is_shift_c_o
);

    logic [6:0] f7_sh;
    aluop_t     op;
    logic       ill;

    // Decode; on RV64 funct7[0] carries shamt[5] for immediate shifts
    always_comb begin
        f7_sh = funct7_i;
        if (XLEN == 64) f7_sh[0] = 1'b0;
        op  = aluop_nop;
        ill = 1'b0;
        case (opcode_i)
            op_rtype: begin
                if (funct7_i == f7_base)                         op = base_aluop(funct3_i);
                else if (funct7_i == f7_alt && funct3_i == 3'b000) op = aluop_sub;
                else if (funct7_i == f7_alt && funct3_i == 3'b101) op = aluop_sra;
                else                                               ill = 1'b1;
            end
            op_itype: begin
                case (funct3_i)
                    3'b001: begin
                        if (f7_sh == f7_base) op = aluop_sll;
                        else                  ill = 1'b1;
                    end
                    3'b101: begin
                        if (f7_sh == f7_base)     op = aluop_srl;
                        else if (f7_sh == f7_alt) op = aluop_sra;
                        else                      ill = 1'b1;
                    end
                    default: op = base_aluop(funct3_i);
                endcase
            end
            op_load, op_store, op_auipc: op = aluop_add;
            op_lui:                      op = aluop_passb;
            op_branch: begin
                case (funct3_i)
                    3'b000, 3'b001: op = aluop_sub;
                    3'b100, 3'b101: op = aluop_slt;
                    3'b110, 3'b111: op = aluop_sltu;
                    default:        ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) op = aluop_nop;
    end

    assign aluop_c_o    = op;
    assign illegal_c_o  = ill;
    assign is_shift_c_o = is_shift_op(op);

endmodule

// File: rtl/riscv_alu_exec.sv
// ALU execute stage: valid/ready handshake, registered result, iterative shifter.
module riscv_alu_exec
    import riscv_alu_exec_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      aluop_o,
    output logic            illegal_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    aluop_t          aluop_q, aluop_d;
    logic            illegal_q, illegal_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    aluop_t          dec_aluop;
    logic            dec_illegal;
    logic            dec_is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [CW-1:0]   step;
    logic            accept;

    riscv_alu_decode #(.XLEN(XLEN)) u_decode (
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .aluop_c_o    (dec_aluop),
        .illegal_c_o  (dec_illegal),
        .is_shift_c_o (dec_is_shift)
    );

    assign shamt      = op_b_i[SHW-1:0];
    assign in_ready_o = (state_q == st_idle) || ((state_q == st_done) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Single-cycle result for non-shift ops (and zero-distance shifts)
    always_comb begin
        alu_res = '0;
        case (dec_aluop)
            aluop_add:   alu_res = op_a_i + op_b_i;
            aluop_sub:   alu_res = op_a_i - op_b_i;
            aluop_slt:   alu_res = XLEN'($signed(op_a_i) < $signed(op_b_i));
            aluop_sltu:  alu_res = XLEN'(op_a_i < op_b_i);
            aluop_xor:   alu_res = op_a_i ^ op_b_i;
            aluop_or:    alu_res = op_a_i | op_b_i;
            aluop_and:   alu_res = op_a_i & op_b_i;
            aluop_passb: alu_res = op_b_i;
            aluop_sll, aluop_srl, aluop_sra: alu_res = op_a_i;
            default:     alu_res = '0;
        endcase
    end

    // Next-state: shift iteration, completion hold, and accept of a new op
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        aluop_d     = aluop_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        step        = (cnt_q < STEP) ? cnt_q : STEP;

        case (state_q)
            st_idle: state_d = st_idle;
            st_shift: begin
                cnt_d = cnt_q - step;
                case (aluop_q)
                    aluop_sll: result_d = result_q << step;
                    aluop_srl: result_d = result_q >> step;
                    default:   result_d = $unsigned($signed(result_q) >>> step);
                endcase
                if (cnt_d == '0) begin
                    state_d     = st_done;
                    out_valid_d = 1'b1;
                end
            end
            st_done: begin
                if (out_ready_i) begin
                    state_d     = st_idle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = st_idle;
        endcase

        if (accept) begin
            aluop_d   = dec_aluop;
            illegal_d = dec_illegal;
            if (dec_is_shift && (shamt != '0)) begin
                state_d     = st_shift;
                result_d    = op_a_i;
                cnt_d       = CW'(shamt);
                out_valid_d = 1'b0;
            end else begin
                state_d     = st_done;
                result_d    = alu_res;
                out_valid_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= st_idle;
            result_q    <= '0;
            aluop_q     <= aluop_nop;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            aluop_q     <= aluop_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign aluop_o     = aluop_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_riscv_alu_exec.sv
// Directed self-checking bench for riscv_alu_exec (SHIFT_STEP 1 and 4 instances).
module tb_riscv_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        rdy1, vld1, ill1;
    logic [31:0] res1;
    logic [3:0]  aop1;
    logic        rdy4, vld4, ill4;
    logic [31:0] res4;
    logic [3:0]  aop4;

    int total = 0;
    int bad   = 0;

    riscv_alu_exec #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .op_a_i(op_a), .op_b_i(op_b), .out_valid_o(vld1), .out_ready_i(out_ready),
        .result_o(res1), .aluop_o(aop1), .illegal_o(ill1)
    );

    riscv_alu_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .op_a_i(op_a), .op_b_i(op_b), .out_valid_o(vld4), .out_ready_i(out_ready),
        .result_o(res4), .aluop_o(aop4), .illegal_o(ill4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
        tick(); tick();
        rst = 1'b0;
        total++; if (vld1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", vld1); end
        total++; if (res1 !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", res1); end
        total++; if (aop1 !== 4'd0) begin bad++; $display("FAIL reset_aluop got=%0d want=0", aop1); end
        total++; if (ill1 !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", ill1); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", rdy1); end
        total++; if ({rdy4, vld4, ill4, aop4, res4} !== {1'b1, 1'b0, 1'b0, 4'd0, 32'h0}) begin
            bad++; $display("FAIL reset_dut4 got=%b/%b/%b/%0d/%h want=1/0/0/0/0", rdy4, vld4, ill4, aop4, res4);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000000, 32'hFFFF_FFFF, 32'h1);
        tick();
        in_valid = 1'b0;
        total++; if (vld1 !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", vld1); end
        total++; if (res1 !== 32'h0) begin bad++; $display("FAIL add_result got=%h want=00000000", res1); end
        total++; if (aop1 !== 4'd1) begin bad++; $display("FAIL add_aluop got=%0d want=1", aop1); end
        tick();
        total++; if (vld1 !== 1'b0) begin bad++; $display("FAIL add_release got=%0b want=0", vld1); end
    endtask

    task automatic test_srai();
        int lat1 = 0;
        int lat4 = 0;
        logic [31:0] r1 = '0;
        logic [31:0] r4 = '0;
        out_ready = 1'b1;
        drive(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (lat1 == 0 && vld1 === 1'b1) begin lat1 = i; r1 = res1; end
            if (lat4 == 0 && vld4 === 1'b1) begin lat4 = i; r4 = res4; end
            if (i == 2) begin
                total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL srai_busy_ready got=%0b want=0", rdy1); end
            end
            tick();
        end
        total++; if (lat1 != 5) begin bad++; $display("FAIL srai_step1_latency got=%0d want=5", lat1); end
        total++; if (r1 !== 32'hF800_0000) begin bad++; $display("FAIL srai_step1_result got=%h want=f8000000", r1); end
        total++; if (lat4 != 2) begin bad++; $display("FAIL srai_step4_latency got=%0d want=2", lat4); end
        total++; if (r4 !== 32'hF800_0000) begin bad++; $display("FAIL srai_step4_result got=%h want=f8000000", r4); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (vld1 !== 1'b1 || res1 !== 32'hFFFF_FFFE) begin
                bad++; $display("FAIL sub_hold cyc=%0d got valid=%0b res=%h want 1/fffffffe", i, vld1, res1);
            end
            total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL sub_hold_ready cyc=%0d got=%0b want=0", i, rdy1); end
            tick();
        end
        out_ready = 1'b1;
        drive(7'b0110011, 3'b110, 7'b0000000, 32'h0000_00F0, 32'h0000_000F);
        #1;
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b want=1", rdy1); end
        tick();
        in_valid = 1'b0;
        total++; if (vld1 !== 1'b1 || res1 !== 32'h0000_00FF || aop1 !== 4'd9) begin
            bad++; $display("FAIL b2b_or got valid=%0b res=%h op=%0d want 1/000000ff/9", vld1, res1, aop1);
        end
        tick();
        total++; if (vld1 !== 1'b0) begin bad++; $display("FAIL b2b_release got=%0b want=0", vld1); end
    endtask

    task automatic test_illegal();
        logic [6:0] opc_t [3] = '{7'b1110011, 7'b0110011, 7'b1100011};
        logic [2:0] f3_t  [3] = '{3'b000, 3'b000, 3'b010};
        logic [6:0] f7_t  [3] = '{7'b0000000, 7'b0000001, 7'b0000000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(opc_t[i], f3_t[i], f7_t[i], 32'h55, 32'h66);
            tick();
            drive(7'b0010011, 3'b000, 7'b0000000, 32'd2, 32'd3);
            total++; if (vld1 !== 1'b1 || ill1 !== 1'b1 || res1 !== 32'h0 || aop1 !== 4'd0) begin
                bad++; $display("FAIL illegal_%0d got v=%0b ill=%0b res=%h op=%0d want 1/1/0/0", i, vld1, ill1, res1, aop1);
            end
            tick();
            in_valid = 1'b0;
            total++; if (vld1 !== 1'b1 || ill1 !== 1'b0 || res1 !== 32'd5 || aop1 !== 4'd1) begin
                bad++; $display("FAIL illegal_next_%0d got v=%0b ill=%0b res=%h op=%0d want 1/0/5/1", i, vld1, ill1, res1, aop1);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        drive(7'b1100011, 3'b110, 7'b0000000, 32'd1, 32'hFFFF_FFFF);
        tick();
        drive(7'b1100011, 3'b101, 7'b0000000, 32'd1, 32'hFFFF_FFFF);
        total++; if (aop1 !== 4'd5 || res1 !== 32'd1) begin
            bad++; $display("FAIL bltu got op=%0d res=%h want 5/00000001", aop1, res1);
        end
        tick();
        in_valid = 1'b0;
        total++; if (aop1 !== 4'd4 || res1 !== 32'd0) begin
            bad++; $display("FAIL bge got op=%0d res=%h want 4/00000000", aop1, res1);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        drive(7'b0110011, 3'b001, 7'b0000000, 32'd1, 32'd31);
        tick();
        in_valid = 1'b0;
        total++; if (vld1 !== 1'b0 || rdy1 !== 1'b0) begin
            bad++; $display("FAIL sll_busy got v=%0b rdy=%0b want 0/0", vld1, rdy1);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (vld1 !== 1'b0 || res1 !== 32'h0 || aop1 !== 4'd0 || rdy1 !== 1'b1) begin
            bad++; $display("FAIL midshift_reset got v=%0b res=%h op=%0d rdy=%0b want 0/0/0/1", vld1, res1, aop1, rdy1);
        end
        drive(7'b0110111, 3'b000, 7'b0000000, 32'hDEAD, 32'h1234_5000);
        tick();
        in_valid = 1'b0;
        total++; if (vld1 !== 1'b1 || res1 !== 32'h1234_5000 || aop1 !== 4'd11) begin
            bad++; $display("FAIL lui_after_reset got v=%0b res=%h op=%0d want 1/12345000/11", vld1, res1, aop1);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_srai();
        test_back_to_back();
        test_illegal();
        test_branch();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_alu_exec.md
Name: riscv_alu_exec

Overview:
Parametrised RV32I/RV64I ALU execute stage with full opcode/funct3/funct7 decode. It accepts one operation per valid/ready handshake and produces a registered result. Shifts run on an iterative shifter so the block closes timing for wide XLEN. It sits between the decode/register-read stage and writeback, and supersedes the purely combinational ALU-control decode.

Parameters:
XLEN, 32, operand/result width; 32 or 64 only.
SHIFT_STEP, 1, bits shifted per SHIFT cycle; power of 2, 1..XLEN.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
in_valid_i  input  1  operation present.
in_ready_o  output  1  block can accept an operation this cycle.
opcode_i  input  7  instruction opcode.
funct3_i  input  3  instruction funct3.
funct7_i  input  7  instruction funct7 (imm[11:5] for I-type).
op_a_i  input  XLEN  operand A (rs1 or PC).
op_b_i  input  XLEN  operand B (rs2 or immediate).
out_valid_o  output  1  result valid.
out_ready_i  input  1  consumer accepts result.
result_o  output  XLEN  registered result.
aluop_o  output  4  registered decoded ALU op.
illegal_o  output  1  registered; unsupported encoding.

Behaviour:
- Reset: state IDLE; out_valid_o=0, result_o=0, aluop_o=`aluop_nop, illegal_o=0. Reset mid-SHIFT discards the operation; no result emitted.
- ALU op codes: nop 0, add 1, sub 2, sll 3, slt 4, sltu 5, xor 6, srl 7, sra 8, or 9, and 10, passb 11.
- Decode, keyed on opcode:
  - 0110011 (R): funct3 selects op; funct7=0100000 with funct3 000 -> sub, with 101 -> sra; funct7 0000000 gives the base op; any other funct7 -> illegal.
  - 0010011 (I): as R, but funct7 is ignored except for shifts: SLLI requires funct7 0000000; SRLI/SRAI require 0000000/0100000. XLEN=64 ignores funct7[0] for shifts.
  - 0000011 (load), 0100011 (store), 0010111 (AUIPC) -> add.
  - 0110111 (LUI) -> passb.
  - 1100011 (branch): BEQ/BNE -> sub, BLT/BGE -> slt, BLTU/BGEU -> sltu; funct3 010/011 -> illegal.
  - Everything else -> nop with illegal=1, result 0.
- Shift amount: op_b_i[log2(XLEN)-1:0]. slt/sltu result is 0 or 1, zero-extended. add/sub wrap modulo 2^XLEN.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i).
- An operation is accepted when in_valid_i & in_ready_o.
- FSM:
  - IDLE: on accept of a non-shift op, or a shift with shamt=0 -> DONE next cycle, result computed combinationally and registered (latency 1). On accept of a shift with shamt>0 -> SHIFT; operand A and remaining count are captured.
  - SHIFT: each cycle, shift by min(SHIFT_STEP, remaining) and decrement the count. SRA fills with the captured sign bit. Remaining==0 after the update -> DONE. Latency is 1 + ceil(shamt/SHIFT_STEP). in_ready_o=0.
  - DONE: out_valid_o=1; result_o/aluop_o/illegal_o stable until out_ready_i.
    - out_ready_i & accept: back-to-back operation with no bubble; the next state follows the IDLE rules.
    - out_ready_i & no accept -> IDLE, out_valid_o=0 next cycle.
- Illegal ops complete through DONE like any other op (result 0, illegal_o=1); they never hang.
- Inputs are sampled only on accept; changes at other times have no effect.

Decomposition:
- define.h gains aluop_sub, aluop_sll, aluop_slt, aluop_sltu, aluop_xor, aluop_srl, aluop_sra, aluop_and, aluop_passb. Existing aluop_nop/add/or keep their values.
- define.h also holds the opcode constants (op_rtype, op_itype, op_load, op_store, op_lui, op_auipc, op_branch) and the FSM state encodings.
- One combinational sub-module, riscv_alu_decode: opcode/funct3/funct7 -> aluop, illegal, is_shift.

Test Plan:
- ADD, XLEN=32, out_ready_i=1: A=0xFFFFFFFF, B=1 -> result 0x00000000, aluop 1, out_valid_o one cycle after accept.
- SRAI, opcode 0010011, funct3 101, funct7 0100000, SHIFT_STEP=1: A=0x80000000, B=4 -> result 0xF8000000, out_valid_o 5 cycles after accept. Repeat with SHIFT_STEP=4 -> 2 cycles.
- Back-pressure and back-to-back ops:
  - SUB 5-7 with out_ready_i=0 for 3 cycles -> result 0xFFFFFFFE held and in_ready_o=0.
  - Raise out_ready_i together with a new valid OR 0xF0|0x0F -> OR result 0xFF on the next cycle, no bubble.
- Illegal encodings -> illegal_o=1, result 0, completes in 1 cycle, next op unaffected:
  - opcode 1110011.
  - R-type funct7 0000001.
  - Branch funct3 010.
- Branch decode: BLTU with A=1, B=0xFFFFFFFF -> aluop sltu, result 1; BGE with the same operands -> aluop slt, result 0.
- Reset at SHIFT cycle 2 of SLL shamt=31 -> next cycle IDLE, out_valid_o=0, result_o=0; a following LUI with B=0x12345000 -> result 0x12345000.
